// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the fetch/decode stage register
//
// Contents:
//   stage_state_e   : occupancy of the stage (EMPTY, BUSY, FULL)
//   RV32_NOP        : addi x0,x0,0, shown on the output while it holds no entry
//   if_id_payload_t : {addr, inst} entry held in the output register and the skid
package pipe_pkg;

  // The payload struct carries the RV32 fetch widths. Stages built with wider
  // parameters would need these widened to match.
  localparam int unsigned IF_ID_ADDR_W = 32;
  localparam int unsigned IF_ID_INST_W = 32;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [IF_ID_ADDR_W-1:0] addr;
    logic [IF_ID_INST_W-1:0] inst;
  } if_id_payload_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous active-low reset
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc_i : add one this cycle unless already at all-ones
//   cnt_o : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - fetch/decode stage register with valid/ready and a 2-entry skid
//
// Optional feature macro: PIPE_PERF_CNT_EN (adds stall/flush performance counters)
//
// Ports:
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   flush_i      : synchronous flush, drops every held entry
//   in_valid_i   : upstream entry valid
//   in_ready_o   : stage can accept an entry (decoded from state only)
//   in_addr_i    : upstream PC
//   in_inst_i    : upstream instruction
//   out_valid_o  : output entry valid
//   out_ready_i  : downstream accepts the output entry
//   out_addr_o   : output PC (holds its last value when empty)
//   out_inst_o   : output instruction, NOP_INST when empty
//   stall_cnt_o  : cycles with out_valid_o=1 and out_ready_i=0 (PIPE_PERF_CNT_EN only)
//   flush_cnt_o  : cycles with flush_i=1 (PIPE_PERF_CNT_EN only)
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(RV32_NOP),
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [INST_W-1:0] in_inst_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [INST_W-1:0] out_inst_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  stage_state_e   state_q, state_d;
  if_id_payload_t out_q, skid_q, in_pl;
  logic           in_fire, out_fire;
  logic           load_out_in, load_out_skid, load_skid;

  assign in_pl.addr = IF_ID_ADDR_W'(in_addr_i);
  assign in_pl.inst = IF_ID_INST_W'(in_inst_i);

  // Ready depends only on the state register, so there is no combinational
  // path from out_ready_i back to the fetch stage.
  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush_i) begin
      // Any entry accepted this cycle is discarded; an out_fire this cycle has
      // already been taken by downstream, so nothing is lost from its view.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            load_out_in = 1'b1;
            state_d     = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_out_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready_o is low here, so only the drain direction can fire.
          if (out_fire) begin
            load_out_skid = 1'b1;
            state_d       = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_out_in) begin
        out_q <= in_pl;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_pl;
      end
    end
  end

  // The address register is never cleared by flush, so out_addr_o keeps the
  // last PC while the instruction falls back to the NOP.
  assign out_addr_o = ADDR_W'(out_q.addr);
  assign out_inst_o = out_valid_o ? INST_W'(out_q.inst) : NOP_INST;

`ifdef PIPE_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (out_valid_o & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_i),
    .cnt_o (flush_cnt_o)
  );
`else
  // Counters absent: the stage behaves identically without them.
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_addr_i;
  logic [31:0] in_inst_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_addr_o;
  logic [31:0] out_inst_o;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0]  stall_cnt_o;
  logic [3:0]  flush_cnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

`ifdef PIPE_PERF_CNT_EN
  pipe_stage_skid #(.CNT_W(4)) dut (
`else
  pipe_stage_skid dut (
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_addr_i   (in_addr_i),
    .in_inst_i   (in_inst_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_addr_o  (out_addr_o),
    .out_inst_o  (out_inst_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: push on in_fire, pop on out_fire, cleared by flush/reset.
  logic [63:0] sb_q[$];

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", out_addr_o, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("sb_addr", out_addr_o, e[63:32]);
          check("sb_inst", out_inst_o, e[31:0]);
        end
      end
      if (flush_i) sb_q.delete();
      else if (in_valid_i && in_ready_o) sb_q.push_back({in_addr_i, in_inst_i});
    end
  end

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] i;
    logic        r;
    logic        f;
    logic        eov;
    logic        eir;
    logic [31:0] ea;
    logic [31:0] ei;
  } vec_t;

  vec_t tbl[24];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   seq;
    int   waited;

    // inputs | outputs expected before this cycle's edge
    tbl[0]  = '{1'b1, 32'h0,   32'hA,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   NOP};
    tbl[1]  = '{1'b1, 32'h4,   32'hB,        1'b1, 1'b0, 1'b1, 1'b1, 32'h0,   32'hA};
    tbl[2]  = '{1'b1, 32'h8,   32'hC,        1'b1, 1'b0, 1'b1, 1'b1, 32'h4,   32'hB};
    tbl[3]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h8,   32'hC};
    tbl[4]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h8,   NOP};
    tbl[5]  = '{1'b1, 32'h100, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8,   NOP};
    tbl[6]  = '{1'b1, 32'h104, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h11111111};
    tbl[7]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h11111111};
    tbl[8]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h11111111};
    tbl[9]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h22222222};
    tbl[10] = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h104, NOP};
    tbl[11] = '{1'b1, 32'h180, 32'h44444444, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104, NOP};
    tbl[12] = '{1'b1, 32'h184, 32'h55555555, 1'b0, 1'b0, 1'b1, 1'b1, 32'h180, 32'h44444444};
    tbl[13] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h180, 32'h44444444};
    tbl[14] = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h180, NOP};
    tbl[15] = '{1'b1, 32'h200, 32'h33333333, 1'b1, 1'b1, 1'b0, 1'b1, 32'h180, NOP};
    tbl[16] = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h180, NOP};
    tbl[17] = '{1'b1, 32'h300, 32'h66666666, 1'b1, 1'b0, 1'b0, 1'b1, 32'h180, NOP};
    tbl[18] = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h66666666};
    tbl[19] = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h300, NOP};
    tbl[20] = '{1'b1, 32'h400, 32'h77777777, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, NOP};
    tbl[21] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 32'h77777777};
    tbl[22] = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h77777777};
    tbl[23] = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h400, NOP};

    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_addr_i = '0; in_inst_i = '0;
    #12;
    check("reset out_valid", 32'(out_valid_o), 32'd0);
    check("reset in_ready",  32'(in_ready_o),  32'd1);
    check("reset out_addr",  out_addr_o,       32'h0);
    check("reset out_inst",  out_inst_o,       NOP);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      in_valid_i = tbl[k].v; in_addr_i = tbl[k].a; in_inst_i = tbl[k].i;
      out_ready_i = tbl[k].r; flush_i = tbl[k].f;
      @(negedge clk);
      check($sformatf("vec%0d out_valid", k), 32'(out_valid_o), 32'(tbl[k].eov));
      check($sformatf("vec%0d in_ready", k),  32'(in_ready_o),  32'(tbl[k].eir));
      check($sformatf("vec%0d out_addr", k),  out_addr_o,       tbl[k].ea);
      check($sformatf("vec%0d out_inst", k),  out_inst_o,       tbl[k].ei);
    end

    // Asynchronous reset asserted mid-cycle while FULL.
    @(posedge clk); #1 in_valid_i = 1'b1; in_addr_i = 32'h500; in_inst_i = 32'h88888888;
    out_ready_i = 1'b0; flush_i = 1'b0;
    @(posedge clk); #1 in_addr_i = 32'h504; in_inst_i = 32'h99999999;
    @(posedge clk); #1 in_valid_i = 1'b0;
    #1 check("full before reset in_ready", 32'(in_ready_o), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid_o), 32'd0);
    check("async reset out_inst",  out_inst_o,       NOP);
    check("async reset in_ready",  32'(in_ready_o),  32'd1);
    check("async reset out_addr",  out_addr_o,       32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Random traffic with protocol-correct upstream hold; scoreboard checks order.
    seq = 0;
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!in_valid_i || acc) begin
        in_valid_i = ($urandom_range(0, 3) != 0);
        in_addr_i  = 32'h1000 + 32'(seq) * 4;
        in_inst_i  = $urandom;
        seq++;
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk) acc = in_valid_i && in_ready_o;
    end
    @(posedge clk); #1 in_valid_i = 1'b0; out_ready_i = 1'b1;
    waited = 0;
    while ((sb_q.size() != 0 || out_valid_o) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("drain scoreboard empty", 32'(sb_q.size()), 32'd0);
    check("drain out_valid",        32'(out_valid_o), 32'd0);

`ifdef PIPE_PERF_CNT_EN
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("perf reset stall", 32'(stall_cnt_o), 32'd0);
    check("perf reset flush", 32'(flush_cnt_o), 32'd0);
    @(posedge clk); #1 in_valid_i = 1'b1; in_addr_i = 32'h600; in_inst_i = 32'h1; out_ready_i = 1'b0;
    @(posedge clk); #1 in_valid_i = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("perf stall saturate", 32'(stall_cnt_o), 32'd15);
    flush_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check("perf flush count", 32'(flush_cnt_o), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
